pc_sequencer: RTL
=================

# pc_sequencer

Program counter sequencer for the processor fetch path. Holds the 10-bit instruction address, advances it by 2 each cycle, and loads branch, call and return targets. A small return-address stack handles call/return. Its `pc` output feeds instruction memory and the PC-minus-2 adjust stage, which recovers the address of the instruction currently executing.

## Interface
Parameters:
- `RESET_PC`, default 10'h000: PC value loaded on reset.
- `RAS_DEPTH`, default 4: return-address stack entries; must be a power of 2, from 2 to 16.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `stall`, input, 1: hold PC and stack this cycle.
- `halt`, input, 1: enter HALT state.
- `branch_en`, input, 1: load `branch_target`.
- `branch_target`, input, 10: branch/call destination; bit 0 is ignored and forced to 0.
- `call_en`, input, 1: push `pc_plus2`, then jump to `branch_target`.
- `ret_en`, input, 1: pop the stack into PC.
- `pc`, output, 10: current fetch address; registered.
- `pc_plus2`, output, 10: `pc + 2`, modulo 1024; combinational from `pc`.
- `halted`, output, 1: high while in HALT.
- `ras_overflow`, output, 1: sticky; set when a push hits a full stack.
- `ras_underflow`, output, 1: sticky; set when a pop hits an empty stack.

## Operation
States:
- BOOT: first cycle after reset is released. PC holds `RESET_PC`; the next state is always RUN.
- RUN: normal sequencing.
- HALT: PC and stack are frozen, `halted`=1. Only `reset` exits HALT.

Priority in RUN, highest first: `halt` > `stall` > `ret_en` > `call_en` > `branch_en` > increment.
- `halt`: the next state is HALT and PC holds.
- `stall`: PC, stack pointer and flags hold; all other requests are dropped, not queued.
- `ret_en`, stack not empty: `pc <= top`, depth decrements.
- `ret_en`, stack empty: `ras_underflow` <= 1; PC increments as normal.
- `call_en`: push `pc_plus2`, then `pc <= {branch_target[9:1],1'b0}`.
- `call_en`, stack full: oldest entry is overwritten (circular buffer), depth stays at `RAS_DEPTH`, `ras_overflow` <= 1.
- `branch_en`: `pc <= {branch_target[9:1],1'b0}`.
- Otherwise: `pc <= pc + 2`. Arithmetic is unsigned 10-bit and wraps, so 10'h3FE becomes 10'h000. No carry-out is reported.
- `call_en` and `ret_en` in the same cycle: the return wins and no push happens.

Reset values:
- `pc` = `RESET_PC`, `halted` = 0, both flags = 0.
- Stack depth = 0; stack contents are don't-care.
- State = BOOT.
- Reset asserted mid-operation, including in HALT, forces these values immediately and asynchronously.

## Timing
- Every control input is sampled on the rising edge at the end of cycle t; the new `pc` is visible in cycle t+1. Redirect latency is 1 cycle.
- `pc_plus2` settles in the same cycle as `pc`; it has no register stage.
- `halted` rises in the cycle after `halt` is sampled.
- The sticky flags rise in the cycle after the offending push or pop.
- Control inputs are ignored during BOOT.
- A pushed entry is poppable on the very next cycle; back-to-back call then return returns to the call's `pc_plus2`.

## Configuration
- `PC_SEQ_RAS_EN` defined: the return-address stack and both flags are built as described above.
- `PC_SEQ_RAS_EN` undefined:
  - No stack storage is built.
  - `call_en` behaves exactly as `branch_en`.
  - `ret_en` is ignored and PC increments.
  - `ras_overflow` and `ras_underflow` are tied to 0.
  - Port list is unchanged.

## Structure
- Shared processor package holds:
  - State encoding: BOOT=2'd0, RUN=2'd1, HALT=2'd2.
  - `PC_WIDTH`=10.
  - `PC_STEP`=2.
- One sub-module, `ras_stack`: circular LIFO with push, pop, full, empty and top outputs, parameterised on depth and width. It is instantiated only under `PC_SEQ_RAS_EN`.
- The FSM and PC register stay in `pc_sequencer`.

## Test plan
1. Reset release, no requests: `pc` reads 000 during BOOT, then 002, 004, 006 on successive cycles; `halted`=0.
2. Wrap-around: run `pc` to 3FC with no requests; `pc` goes to 3FE, then 000, with no flag set.
3. Branch and stall: `branch_en` with target 0x155 at pc 010 gives pc 154 on the next cycle. `stall` held for 3 cycles keeps pc at 154; `branch_en` asserted during the stall is ignored.
4. Call/return, depth 4:
   - Call to 0x100 from pc 020: stack top becomes 022, pc 100.
   - Next cycle `ret_en`: pc returns to 022.
   - Five nested calls: `ras_overflow`=1. Five returns: the first four return correct addresses, the fifth sets `ras_underflow`=1 and pc increments.
5. Simultaneous events:
   - `call_en`+`ret_en` together with one entry stacked: pop taken, depth 0, no push.
   - `halt`+`branch_en` together: HALT entered, pc unchanged, `halted`=1.
6. Reset mid-operation: assert `reset` asynchronously in HALT with depth 3. `pc` goes to `RESET_PC` before the next edge; `halted`, flags and depth go to 0; BOOT follows the release.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared PC width, PC step and sequencer FSM state encoding
package pc_sequencer_pkg;
  localparam int PC_WIDTH = 10;
  localparam int PC_STEP  = 2;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
endpackage

// File: rtl/pc_sequencer_ras.sv
// ras_stack: circular LIFO of return addresses; a push onto a full stack overwrites the oldest entry
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_top,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    w_rd;
  assign w_rd    = r_ptr - PW'(1);
  assign o_top   = r_mem[w_rd];
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  // write pointer and occupancy; pop wins over a simultaneous push
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_pop && !o_empty) begin
      r_ptr <= w_rd;
      r_cnt <= r_cnt - CW'(1);
    end else if (i_push) begin
      r_ptr <= r_ptr + PW'(1);
      r_cnt <= o_full ? r_cnt : r_cnt + CW'(1);
    end
  // entry storage, contents need no reset
  always_ff @(posedge i_clk)
    if (i_push && !i_pop) r_mem[r_ptr] <= i_din;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with BOOT/RUN/HALT FSM; return-address stack built under PC_SEQ_RAS_EN
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC  = 10'h000,
  parameter int                  RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                halt,
  input  logic                branch_en,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                call_en,
  input  logic                ret_en,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus2,
  output logic                halted,
  output logic                ras_overflow,
  output logic                ras_underflow
);
  state_t              r_state, w_state;
  logic [PC_WIDTH-1:0] r_pc, w_pc, w_tgt, w_top;
  logic                w_push, w_pop, w_unf, w_empty, w_unused;
`ifdef PC_SEQ_RAS_EN
  localparam bit L_RAS = 1'b1;
  logic w_full, r_ovf, r_unf;
  ras_stack #(.DEPTH(RAS_DEPTH), .WIDTH(PC_WIDTH)) u_ras (
    .i_clk(clk), .i_rst(reset), .i_push(w_push), .i_pop(w_pop), .i_din(pc_plus2),
    .o_top(w_top), .o_full(w_full), .o_empty(w_empty)
  );
  // sticky stack error flags
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (w_push & w_full);
      r_unf <= r_unf | w_unf;
    end
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;
  assign w_unused      = branch_target[0];
`else
  localparam bit L_RAS = 1'b0;
  assign w_top         = '0;
  assign w_empty       = RAS_DEPTH != 0;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
  assign w_unused      = ^{branch_target[0], w_push, w_pop, w_unf};
`endif
  assign w_tgt    = {branch_target[PC_WIDTH-1:1], 1'b0};
  assign pc       = r_pc;
  assign pc_plus2 = r_pc + PC_WIDTH'(PC_STEP);
  assign halted   = r_state == HALT;
  // next state and next PC: halt > stall > ret > call > branch > increment
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_unf   = 1'b0;
    if (r_state == BOOT) begin
      w_state = RUN;
      w_pc    = pc_plus2;
    end else if (r_state == RUN && halt) begin
      w_state = HALT;
    end else if (r_state == RUN && !stall) begin
      if (ret_en && L_RAS) begin
        w_pop = !w_empty;
        w_unf = w_empty;
        w_pc  = w_empty ? pc_plus2 : w_top;
      end else if (call_en || branch_en) begin
        w_push = call_en;
        w_pc   = w_tgt;
      end else begin
        w_pc = pc_plus2;
      end
    end
  end
  // state and PC registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
    end
endmodule
